// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU data memory.
//   SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (1/2/4/8 bytes)
//   state_t             : request FSM states
//   size_bytes()        : byte count for a size encoding
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Wait-state counter width; covers RD_WAIT up to 7.
    localparam int RD_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: combinational size/sign extension of load data.
//   raw         : little-endian bytes gathered from memory, right-aligned
//   size        : access size encoding (SZ_B..SZ_D)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : extended result, XLEN wide
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic sign;
    int   nbits;

    always_comb begin
        case (size)
            SZ_B:    sign = raw[7];
            SZ_H:    sign = raw[15];
            SZ_W:    sign = raw[31];
            default: sign = raw[XLEN-1];
        endcase
        nbits = size_bytes(size) * 8;
        data  = '0;
        for (int i = 0; i < XLEN; i++)
            data[i] = (i < nbits) ? raw[i] : (sign & ~is_unsigned);
    end

endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressed data memory behind a valid/ready load/store
// port with one outstanding request.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid/ready  : request handshake
//   req_we           : 1 = store, 0 = load
//   req_size         : SZ_B/SZ_H/SZ_W/SZ_D
//   req_unsigned     : load zero-extends when 1
//   req_addr/wdata   : byte address, right-aligned store data
//   rsp_valid/ready  : response handshake
//   rsp_rdata        : extended load data (0 for stores and faults)
//   rsp_err          : access faulted, memory untouched
// Build option: define LSU_DATA_MEM_MISALIGN_CHECK_EN to fault accesses whose
// address is not a multiple of the access size; otherwise misaligned accesses
// proceed byte-wise.
module lsu_data_mem
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int RD_WAIT     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int NB = XLEN / 8;
    localparam logic [RD_CNT_W-1:0] RD_W = RD_CNT_W'(RD_WAIT);

    logic [7:0] mem [DEPTH_BYTES];

    state_t              state, state_d;
    logic [RD_CNT_W-1:0] cnt, cnt_d;
    logic [AW-1:0]       addr_q;
    logic [1:0]          size_q;
    logic                uns_q;

    logic            accept;
    logic [XLEN-1:0] nbytes;
    logic            range_err, size_err, align_err, acc_err;
    logic [AW-1:0]   rd_addr;
    logic [1:0]      rd_size;
    logic            rd_uns;
    logic [XLEN-1:0] raw, ext;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // Written as addr > DEPTH - n so huge addresses cannot wrap the sum.
    assign nbytes    = XLEN'(size_bytes(req_size));
    assign range_err = req_addr > (XLEN'(DEPTH_BYTES) - nbytes);
    assign size_err  = (XLEN == 32) && (req_size == SZ_D);
`ifdef LSU_DATA_MEM_MISALIGN_CHECK_EN
    assign align_err = |(req_addr & (nbytes - XLEN'(1)));
`else
    assign align_err = 1'b0;
`endif
    assign acc_err   = range_err | size_err | align_err;

    // Zero-wait loads read straight from the request; waited loads from the
    // fields captured at accept.
    assign rd_addr = (state == ST_IDLE) ? req_addr[AW-1:0] : addr_q;
    assign rd_size = (state == ST_IDLE) ? req_size : size_q;
    assign rd_uns  = (state == ST_IDLE) ? req_unsigned : uns_q;

    // Index wraps modulo depth; out-of-range bytes are never used because
    // such accesses fault.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NB; i++)
            raw[8*i +: 8] = mem[rd_addr + AW'(i)];
    end

    lsu_load_extend #(.XLEN(XLEN)) u_ext (
        .raw         (raw),
        .size        (rd_size),
        .is_unsigned (rd_uns),
        .data        (ext)
    );

    // Memory has no reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && rst_n && req_we && !acc_err)
            for (int i = 0; i < NB; i++)
                if (i < size_bytes(req_size))
                    mem[req_addr[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: if (accept) begin
                if (!req_we && !acc_err && (RD_WAIT > 0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = RD_CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == RD_W) state_d = ST_RESP;
                else             cnt_d   = cnt + RD_CNT_W'(1);
            end
            ST_RESP: if (rsp_ready) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr[AW-1:0];
                size_q <= req_size;
                uns_q  <= req_unsigned;
            end
            if (state == ST_IDLE && state_d == ST_RESP) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!req_we && !acc_err) ? ext : '0;
            end else if (state == ST_WAIT && state_d == ST_RESP) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= ext;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: randomized self-checking bench for lsu_data_mem
// (XLEN=64, DEPTH_BYTES=256, RD_WAIT=3). A byte-array model predicts each
// response; a per-cycle compare process checks handshake and response fields.
module tb_lsu_data_mem;

    localparam int XLEN    = 64;
    localparam int DEPTH   = 256;
    localparam int RD_WAIT = 3;

    logic            clk, rst_n;
    logic            req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]      req_size;
    logic [63:0]     req_addr, req_wdata;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [63:0]     rsp_rdata;

    lsu_data_mem #(.XLEN(XLEN), .DEPTH_BYTES(DEPTH), .RD_WAIT(RD_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [7:0]  mm [DEPTH];
    logic        busy = 1'b0;
    int          acc_cyc = 0;
    int          lat = 0;
    logic [63:0] e_data = '0;
    logic        e_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    endtask

    // Per-cycle compare: while a request is outstanding the response must
    // appear exactly lat cycles after the handshake cycle and hold steady.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ev;
            ev = busy && (cyc >= acc_cyc + lat);
            chk("req_ready", 64'(req_ready), 64'(!busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, e_data);
                chk("rsp_err", 64'(rsp_err), 64'(e_err));
            end
        end
    end

    // Model of one access: fault rule, little-endian gather, extension.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] data, output logic err);
        int nb;
        nb   = 1 << size;
        err  = (addr >= 64'(DEPTH)) || (addr + 64'(nb) > 64'(DEPTH));
`ifdef LSU_DATA_MEM_MISALIGN_CHECK_EN
        if (addr % 64'(nb) != 0) err = 1'b1;
`endif
        data = '0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++) data = data | (64'(mm[addr + 64'(i)]) << (8*i));
            if (!uns && nb < 8 && data[8*nb-1]) data = data | (~64'd0 << (8*nb));
        end
        if (!err && we)
            for (int i = 0; i < nb; i++) mm[addr + 64'(i)] = wdata[8*i +: 8];
    endtask

    // One full transaction; inputs are scrambled right after accept.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                        output logic [63:0] got, output logic got_err, output logic [63:0] mdl);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        @(posedge clk); #1;
        model(we, size, uns, addr, wdata, e_data, e_err);
        mdl     = e_data;
        lat     = (we || e_err) ? 1 : RD_WAIT + 1;
        acc_cyc = cyc - 1;
        busy    = 1'b1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
        req_unsigned = $urandom_range(0, 1);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        repeat (lat - 1 + hold) @(posedge clk);
        #1;
        got = rsp_rdata; got_err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] got, mdl, v;
        logic        gerr;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #2;
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fill: byte i = i*7+3
        for (int k = 0; k < DEPTH / 8; k++) begin
            for (int b = 0; b < 8; b++) v[8*b +: 8] = 8'((8*k + b) * 7 + 3);
            xact(1'b1, 2'd3, 1'b0, 64'(8*k), v, 0, got, gerr, mdl);
        end

        xact(1'b1, 2'd3, 1'b0, 64'd8, 64'h1122334455667788, 0, got, gerr, mdl);
        chk("store d err", 64'(gerr), 64'd0);
        xact(1'b0, 2'd3, 1'b0, 64'd8, '0, 0, got, gerr, mdl);
        chk("load d", got, 64'h1122334455667788);
        chk("model load d", mdl, 64'h1122334455667788);
        xact(1'b0, 2'd0, 1'b1, 64'd8, '0, 1, got, gerr, mdl);
        chk("load b", got, 64'h88);

        xact(1'b1, 2'd0, 1'b0, 64'd16, 64'hABCD_0080, 0, got, gerr, mdl);
        xact(1'b0, 2'd0, 1'b0, 64'd16, '0, 0, got, gerr, mdl);
        chk("load sb", got, 64'hFFFF_FFFF_FFFF_FF80);
        chk("model load sb", mdl, 64'hFFFF_FFFF_FFFF_FF80);
        xact(1'b0, 2'd0, 1'b1, 64'd16, '0, 0, got, gerr, mdl);
        chk("load ub", got, 64'h80);

        xact(1'b1, 2'd2, 1'b0, 64'(DEPTH - 2), 64'hDEADBEEF, 0, got, gerr, mdl);
        chk("oob store err", 64'(gerr), 64'd1);
        chk("oob store rdata", got, 64'd0);
        xact(1'b0, 2'd3, 1'b1, 64'(DEPTH - 8), '0, 0, got, gerr, mdl);
        chk("tail unchanged", got, 64'hFCF5EEE7E0D9D2CB);
        xact(1'b0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, '0, 0, got, gerr, mdl);
        chk("huge addr err", 64'(gerr), 64'd1);

        xact(1'b0, 2'd1, 1'b1, 64'd3, '0, 0, got, gerr, mdl);
`ifdef LSU_DATA_MEM_MISALIGN_CHECK_EN
        chk("misalign err", 64'(gerr), 64'd1);
        chk("misalign rdata", got, 64'd0);
`else
        chk("misalign err", 64'(gerr), 64'd0);
        chk("misalign rdata", got, 64'h1F18);
`endif

        // Long backpressure on a waited load
        xact(1'b0, 2'd3, 1'b0, 64'd8, '0, 5, got, gerr, mdl);
        chk("backpressure load", got, 64'h1122334455667788);

        // Reset while in WAIT
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 1'b1; acc_cyc = cyc - 1; lat = RD_WAIT + 1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("wait reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("wait reset req_ready", 64'(req_ready), 64'd1);
        busy = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        xact(1'b0, 2'd3, 1'b0, 64'd8, '0, 0, got, gerr, mdl);
        chk("load after reset", got, 64'h1122334455667788);
        chk("load after reset err", 64'(gerr), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [63:0] a;
            logic [1:0]  s;
            s = 2'($urandom);
            if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
            else if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(0, DEPTH / 8 - 1)) << s;
            else a = 64'($urandom_range(0, DEPTH + 8));
            xact(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a,
                 {$urandom, $urandom}, $urandom_range(0, 2), got, gerr, mdl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
- REQ-001: Parameter XLEN, default 64, data and address width (32 or 64).
- REQ-002: Parameter DEPTH_BYTES, default 256, byte capacity; power of two, at least 8.
- REQ-003: Parameter RD_WAIT, default 1, load wait states (0..7) between accept and response.
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: req_valid  input  1  request present.
- REQ-007: req_ready  output  1  block can accept a request.
- REQ-008: req_we  input  1  1 = store, 0 = load.
- REQ-009: req_size  input  2  access size: 0 byte, 1 half, 2 word, 3 double (3 is illegal when XLEN=32).
- REQ-010: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- REQ-011: req_addr  input  XLEN  byte address.
- REQ-012: req_wdata  input  XLEN  store data, right-aligned.
- REQ-013: rsp_valid  output  1  response present.
- REQ-014: rsp_ready  input  1  consumer accepts the response.
- REQ-015: rsp_rdata  output  XLEN  load data, extended; 0 for stores and errors.
- REQ-016: rsp_err  output  1  access faulted; no memory side effect occurred.

Function
- REQ-017: A request is accepted on a rising edge where req_valid && req_ready; each accepted request yields exactly one response.
- REQ-018: The FSM shall have three states: IDLE (req_ready=1), WAIT (counting load wait states), RESP (rsp_valid=1, held until rsp_ready).
- REQ-019: Transitions: IDLE to WAIT on an accepted load with RD_WAIT>0; otherwise IDLE to RESP on accept; WAIT to RESP when the counter reaches RD_WAIT; RESP to IDLE on rsp_ready.
- REQ-020: Request fields shall be registered at accept; input changes after accept shall have no effect.
- REQ-021: A store shall write 2^req_size bytes, little-endian (lowest byte at the lowest address), at the accept edge; no other bytes change.
- REQ-022: A load shall return bytes little-endian, extended from bit 8*2^size-1 to XLEN per req_unsigned, captured at entry to RESP.
- REQ-023: Response latency shall be 1 cycle for stores and errors, and RD_WAIT+1 cycles for loads.
- REQ-024: An access with addr + 2^size > DEPTH_BYTES, or an illegal size, shall set rsp_err=1, write nothing and return rdata 0.
- REQ-025: rsp_valid, rsp_rdata and rsp_err shall remain stable while rsp_valid=1 and rsp_ready=0.
- REQ-026: req_ready shall be 0 in WAIT and RESP; there shall be no request/response overlap (one outstanding request).

Reset
- REQ-027: Asserting rst_n=0 mid-operation shall abort any in-flight request, return the FSM to IDLE and clear the counter.
- REQ-028: Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- REQ-029: Memory array contents shall not be affected by reset; a store already committed at accept stays committed.

Configuration
- REQ-030: With macro LSU_DATA_MEM_MISALIGN_CHECK_EN defined, an address not aligned to 2^size shall fault per REQ-024.
- REQ-031: Without the macro, misaligned accesses shall proceed byte-wise across the boundary; only the range and size checks of REQ-024 fault.

Structure
- REQ-032: Package lsu_pkg shall hold the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state typedef.
- REQ-033: Sub-module lsu_load_extend shall implement the combinational size/sign extension.

Verification
- REQ-034: Store 0x1122334455667788, size 3, to addr 8, then load size 3 from addr 8: rdata=0x1122334455667788; load size 0 from addr 8: rdata=0x88.
- REQ-035: Store byte 0x80 to addr 16; load signed byte: rdata=0xFFFFFFFFFFFFFF80; load unsigned byte: rdata=0x80.
- REQ-036: With RD_WAIT=3, hold rsp_ready=0 for 5 cycles after rsp_valid: response appears 4 cycles after accept, stays stable, req_ready=0 throughout.
- REQ-037: Store size 2 to addr DEPTH_BYTES-2: rsp_err=1 and a load of the last 8 bytes is unchanged.
- REQ-038: With the macro defined, load size 1 from addr 3: rsp_err=1; without the macro: data is bytes 3..4.
- REQ-039: Pull rst_n low during WAIT: rsp_valid=0, req_ready=1 immediately; a subsequent load succeeds.
